// File: rtl/keypad_scan_4x4.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scan_4x4
// Purpose  : Scans a 4x4 active-low matrix keypad one column at a time,
//            debounces press and release, and holds the last accepted key
//            code as a level for the downstream display logic.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk       in   1  system clock
//   rst       in   1  synchronous, active-high reset
//   row       in   4  keypad rows, active low, asynchronous to clk
//   col       out  4  column drive, active low, exactly one bit low
//   key       out  4  last accepted key code = row_index*4 + col_index
//   key_valid out  1  one-cycle pulse when a new key is accepted
//   key_down  out  1  high while the accepted key is held
// ============================================================================
module keypad_scan_4x4 #(
  parameter int SCAN_DIV     = 50000,  // clock cycles per scan tick, >= 2
  parameter int DEBOUNCE_CNT = 20      // qualifying ticks to accept, >= 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_down
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);

  localparam logic [DIV_W-1:0] c_DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] c_CNT_DONE = CNT_W'(DEBOUNCE_CNT);
  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] c_ST_SCAN     = 2'd0;
  localparam logic [1:0] c_ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] c_ST_PRESSED  = 2'd2;

  logic [3:0]       r_row_meta;
  logic [3:0]       r_row_s;
  logic [DIV_W-1:0] r_div;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_state;
  logic [3:0]       r_pat;
  logic [1:0]       r_row_idx;
  logic [3:0]       r_col;
  logic [3:0]       r_key;
  logic             r_key_valid;
  logic             r_key_down;

  logic             w_tick;
  logic             w_rows_idle;
  logic [1:0]       w_row_idx;
  logic [1:0]       w_col_idx;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_tick      = (r_div == c_DIV_LAST);
  assign w_rows_idle = (r_row_s == 4'b1111);
  // r_cnt never exceeds DEBOUNCE_CNT-1 when incremented, so no wrap.
  assign w_cnt_inc   = r_cnt + 1'b1;

  // Lowest-index low row wins when several keys share the driven column.
  always_comb begin
    w_row_idx = 2'd3;
    if (!r_row_s[0])      w_row_idx = 2'd0;
    else if (!r_row_s[1]) w_row_idx = 2'd1;
    else if (!r_row_s[2]) w_row_idx = 2'd2;
  end

  always_comb begin
    case (r_col)
      4'b1110: w_col_idx = 2'd0;
      4'b1101: w_col_idx = 2'd1;
      4'b1011: w_col_idx = 2'd2;
      default: w_col_idx = 2'd3;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_row_meta  <= 4'b1111;
      r_row_s     <= 4'b1111;
      r_div       <= '0;
      r_cnt       <= '0;
      r_state     <= c_ST_SCAN;
      r_pat       <= 4'b1111;
      r_row_idx   <= 2'd0;
      r_col       <= 4'b1110;
      r_key       <= 4'h0;
      r_key_valid <= 1'b0;
      r_key_down  <= 1'b0;
    end else begin
      r_row_meta  <= row;
      r_row_s     <= r_row_meta;
      r_key_valid <= 1'b0;
      r_div       <= w_tick ? '0 : r_div + 1'b1;

      if (w_tick) begin
        case (r_state)
          c_ST_SCAN: begin
            if (w_rows_idle) begin
              r_col <= {r_col[2:0], r_col[3]};
            end else begin
              r_pat     <= r_row_s;
              r_row_idx <= w_row_idx;
              if (c_CNT_ONE == c_CNT_DONE) begin
                // Single-tick debounce: the first sighting is the acceptance.
                r_key       <= {w_row_idx, w_col_idx};
                r_key_valid <= 1'b1;
                r_key_down  <= 1'b1;
                r_cnt       <= '0;
                r_state     <= c_ST_PRESSED;
              end else begin
                r_cnt   <= c_CNT_ONE;
                r_state <= c_ST_DEBOUNCE;
              end
            end
          end

          c_ST_DEBOUNCE: begin
            if (r_row_s == r_pat) begin
              if (w_cnt_inc == c_CNT_DONE) begin
                r_key       <= {r_row_idx, w_col_idx};
                r_key_valid <= 1'b1;
                r_key_down  <= 1'b1;
                r_cnt       <= '0;
                r_state     <= c_ST_PRESSED;
              end else begin
                r_cnt <= w_cnt_inc;
              end
            end else begin
              // Column is kept so the same column is re-examined next tick.
              r_cnt   <= '0;
              r_state <= c_ST_SCAN;
            end
          end

          c_ST_PRESSED: begin
            if (w_rows_idle) begin
              if (w_cnt_inc == c_CNT_DONE) begin
                r_key_down <= 1'b0;
                r_cnt      <= '0;
                r_col      <= {r_col[2:0], r_col[3]};
                r_state    <= c_ST_SCAN;
              end else begin
                r_cnt <= w_cnt_inc;
              end
            end else begin
              r_cnt <= '0;
            end
          end

          default: begin
            r_cnt   <= '0;
            r_state <= c_ST_SCAN;
          end
        endcase
      end
    end
  end

  assign col       = r_col;
  assign key       = r_key;
  assign key_valid = r_key_valid;
  assign key_down  = r_key_down;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_4x4.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_scan_4x4
// Purpose  : Self-checking bench for keypad_scan_4x4 with a behavioural
//            keypad matrix, a key-code scoreboard and directed scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_scan_4x4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key;
  logic       key_valid;
  logic       key_down;

  logic [3:0] pressed [4];   // pressed[r][c]
  logic [3:0] exp_q [$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         n_valid = 0;
  int         exp_valid = 0;
  logic       prev_valid = 1'b0;

  keypad_scan_4x4 #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .row       (row),
    .col       (col),
    .key       (key),
    .key_valid (key_valid),
    .key_down  (key_down)
  );

  always #5 clk = ~clk;

  // Keypad model: a row is pulled low only through a pressed key whose
  // column is currently driven low.
  always_comb begin
    row = 4'b1111;
    for (int r = 0; r < 4; r++) row[r] = ~|(pressed[r] & ~col);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: each key_valid pulse pops the code pushed by the stimulus.
  always @(negedge clk) begin
    if (key_valid === 1'b1) begin
      n_valid++;
      check("valid_one_cycle", {31'd0, prev_valid}, 32'd0);
      check("valid_expected", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (exp_q.size() > 0) check("sb_key", {28'd0, key}, {28'd0, exp_q.pop_front()});
    end
    prev_valid = (key_valid === 1'b1);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_down(input string tag, input logic val, output int cyc);
    cyc = 0;
    while (key_down !== val && cyc < 300) begin
      step(1);
      cyc++;
    end
    check(tag, {31'd0, key_down}, {31'd0, val});
  endtask

  task automatic wait_col(input logic [3:0] target);
    int n;
    n = 0;
    while (col === target && n < 40) begin step(1); n++; end
    n = 0;
    while (col !== target && n < 40) begin step(1); n++; end
    check("wait_col", {28'd0, col}, {28'd0, target});
  endtask

  task automatic press(input int r, input int c, input logic [3:0] code);
    pressed[r][c] = 1'b1;
    exp_q.push_back(code);
    exp_valid++;
  endtask

  initial begin
    int cyc;
    for (int r = 0; r < 4; r++) pressed[r] = 4'b0000;

    // 1. Reset and idle rotation
    rst = 1'b1;
    step(3);
    check("rst_col", {28'd0, col}, 32'hE);
    check("rst_key", {28'd0, key}, 32'h0);
    check("rst_valid", {31'd0, key_valid}, 32'd0);
    check("rst_down", {31'd0, key_down}, 32'd0);
    rst = 1'b0;
    step(3);
    check("idle_col_hold", {28'd0, col}, 32'hE);
    step(1);
    check("idle_col1", {28'd0, col}, 32'hD);
    step(4);
    check("idle_col2", {28'd0, col}, 32'hB);
    step(4);
    check("idle_col3", {28'd0, col}, 32'h7);
    step(4);
    check("idle_col0", {28'd0, col}, 32'hE);

    // 2. Clean press (2,1), held; extra same-column key during hold
    press(2, 1, 4'd9);
    wait_down("press9_down", 1'b1, cyc);
    check("press9_key", {28'd0, key}, 32'd9);
    for (int i = 0; i < 40; i++) begin
      if (i == 10) pressed[3][1] = 1'b1;
      if (i == 20) pressed[3][1] = 1'b0;
      step(1);
      check("hold9_col", {28'd0, col}, 32'hD);
      check("hold9_down", {31'd0, key_down}, 32'd1);
    end
    check("hold9_nvalid", n_valid, exp_valid);
    pressed[2][1] = 1'b0;
    wait_down("rel9_down", 1'b0, cyc);
    check("rel9_latency", (cyc >= 11 && cyc <= 14) ? 32'd1 : 32'd0, 32'd1);
    check("rel9_key", {28'd0, key}, 32'd9);
    check("rel9_col", {28'd0, col}, 32'hB);

    // 3. Bounce on (0,0) for one tick
    wait_col(4'b1110);
    pressed[0][0] = 1'b1;
    step(4);
    check("bounce_col_held", {28'd0, col}, 32'hE);
    pressed[0][0] = 1'b0;
    step(4);
    check("bounce_col_back", {28'd0, col}, 32'hE);
    check("bounce_down", {31'd0, key_down}, 32'd0);
    step(4);
    check("bounce_col_next", {28'd0, col}, 32'hD);
    check("bounce_key", {28'd0, key}, 32'd9);
    check("bounce_nvalid", n_valid, exp_valid);

    // 4. Release glitch on key (1,2)
    press(1, 2, 4'd6);
    wait_down("press6_down", 1'b1, cyc);
    pressed[1][2] = 1'b0;
    step(8);
    check("glitch_down_a", {31'd0, key_down}, 32'd1);
    pressed[1][2] = 1'b1;
    step(4);
    check("glitch_down_b", {31'd0, key_down}, 32'd1);
    pressed[1][2] = 1'b0;
    step(11);
    check("glitch_down_c", {31'd0, key_down}, 32'd1);
    step(1);
    check("glitch_release", {31'd0, key_down}, 32'd0);
    check("glitch_col", {28'd0, col}, 32'h7);
    check("glitch_key", {28'd0, key}, 32'd6);

    // 5. Same-column double press in column 3
    pressed[3][3] = 1'b1;
    press(1, 3, 4'd7);
    wait_down("dbl_down", 1'b1, cyc);
    check("dbl_key", {28'd0, key}, 32'd7);
    pressed[1][3] = 1'b0;
    step(30);
    check("dbl_still_down", {31'd0, key_down}, 32'd1);
    check("dbl_key_hold", {28'd0, key}, 32'd7);
    check("dbl_nvalid", n_valid, exp_valid);
    pressed[3][3] = 1'b0;
    wait_down("dbl_rel", 1'b0, cyc);
    press(3, 3, 4'hF);
    wait_down("f_down", 1'b1, cyc);
    check("f_key", {28'd0, key}, 32'hF);
    pressed[3][3] = 1'b0;
    wait_down("f_rel", 1'b0, cyc);

    // 6. Reset during the 2nd qualifying debounce tick
    wait_col(4'b1110);
    pressed[0][0] = 1'b1;
    step(7);
    check("mid_db_down", {31'd0, key_down}, 32'd0);
    rst = 1'b1;
    step(1);
    check("mid_rst_col", {28'd0, col}, 32'hE);
    check("mid_rst_key", {28'd0, key}, 32'h0);
    check("mid_rst_valid", {31'd0, key_valid}, 32'd0);
    check("mid_rst_down", {31'd0, key_down}, 32'd0);
    rst = 1'b0;
    exp_q.push_back(4'd0);
    exp_valid++;
    step(11);
    check("fresh_not_yet", {31'd0, key_down}, 32'd0);
    step(1);
    check("fresh_down", {31'd0, key_down}, 32'd1);
    check("fresh_valid", {31'd0, key_valid}, 32'd1);
    check("fresh_key", {28'd0, key}, 32'd0);
    pressed[0][0] = 1'b0;
    wait_down("fresh_rel", 1'b0, cyc);
    step(2);

    check("sb_empty", exp_q.size(), 32'd0);
    check("total_valid", n_valid, exp_valid);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
